// File: rtl/bus_grant_controller.sv
// bus_grant_controller: tenure-based round-robin bus grant controller.
// A grant is held until its owner pulses done or drops req, followed by one
// dead turnaround cycle. The eligible set is req masked by a run-time enable
// mask loaded through the config write port.
// Optional feature: define BUS_GRANT_TIMEOUT_EN to enable the tenure limit
// (config addr 01) that forces release and pulses timeout.
module bus_grant_controller #(
    parameter int NUM_MASTERS = 4,
    parameter int ID_W        = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [NUM_MASTERS-1:0] done,
    output logic [NUM_MASTERS-1:0] grant,
    output logic                   grant_valid,
    output logic [ID_W-1:0]        grant_id,
    input  logic                   config_wr,
    input  logic [1:0]             config_addr,
    input  logic [7:0]             config_data,
    output logic                   timeout
);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        RELEASE
    } state_t;

    state_t                 state;
    logic [ID_W-1:0]        ptr;
    logic [NUM_MASTERS-1:0] mask;
    logic [NUM_MASTERS-1:0] eligible;
    logic                   found;
    logic [ID_W-1:0]        pick;
    logic [NUM_MASTERS-1:0] pick_onehot;
    logic                   owner_release;
    logic [ID_W-1:0]        next_ptr;
    int unsigned            idx;

`ifdef BUS_GRANT_TIMEOUT_EN
    logic [7:0]             limit;
    logic [7:0]             tenure;
`endif

    // Upper config_data bits are only partly consumed for small NUM_MASTERS.
    logic unused_cfg_bits;
    assign unused_cfg_bits = ^config_data;

    assign eligible      = req & mask;
    assign owner_release = done[grant_id] | ~req[grant_id];
    assign next_ptr      = (grant_id == ID_W'(NUM_MASTERS - 1)) ? '0 : grant_id + ID_W'(1);

    // Round-robin pick: first eligible index at or after ptr, wrapping.
    always_comb begin
        found       = 1'b0;
        pick        = '0;
        idx         = 0;
        pick_onehot = '0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            idx = (i + 32'(ptr)) % 32'(NUM_MASTERS);
            if (!found && eligible[idx]) begin
                found = 1'b1;
                pick  = ID_W'(idx);
            end
        end
        pick_onehot[pick] = 1'b1;
    end

    // Grant FSM with config registers and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            ptr         <= '0;
            mask        <= '1;
            grant       <= '0;
            grant_valid <= 1'b0;
            grant_id    <= '0;
            timeout     <= 1'b0;
`ifdef BUS_GRANT_TIMEOUT_EN
            limit       <= '0;
            tenure      <= '0;
`endif
        end else begin
            timeout <= 1'b0;
            if (config_wr && config_addr == 2'b00) begin
                mask <= config_data[NUM_MASTERS-1:0];
            end
`ifdef BUS_GRANT_TIMEOUT_EN
            if (config_wr && config_addr == 2'b01) begin
                limit <= config_data;
            end
`endif
            case (state)
                IDLE: begin
                    if (found) begin
                        state       <= GRANT;
                        grant       <= pick_onehot;
                        grant_valid <= 1'b1;
                        grant_id    <= pick;
`ifdef BUS_GRANT_TIMEOUT_EN
                        tenure      <= '0;
`endif
                    end
                end
                GRANT: begin
                    if (owner_release) begin
                        state       <= RELEASE;
                        grant       <= '0;
                        grant_valid <= 1'b0;
                        ptr         <= next_ptr;
                    end
`ifdef BUS_GRANT_TIMEOUT_EN
                    // tenure counts completed grant cycles; expiry fires on the
                    // edge that ends the L-th cycle.
                    else if (limit != 8'd0 && tenure == limit - 8'd1) begin
                        state       <= RELEASE;
                        grant       <= '0;
                        grant_valid <= 1'b0;
                        ptr         <= next_ptr;
                        timeout     <= 1'b1;
                    end else begin
                        tenure <= tenure + 8'd1;
                    end
`endif
                end
                RELEASE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_grant_controller.sv
// tb_bus_grant_controller: directed-vector self-checking bench.
module tb_bus_grant_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req;
    logic [3:0] done;
    logic [3:0] grant;
    logic       grant_valid;
    logic [1:0] grant_id;
    logic       config_wr;
    logic [1:0] config_addr;
    logic [7:0] config_data;
    logic       timeout;

    int n_checks = 0;
    int n_errors = 0;

    bus_grant_controller #(
        .NUM_MASTERS(4),
        .ID_W       (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .done       (done),
        .grant      (grant),
        .grant_valid(grant_valid),
        .grant_id   (grant_id),
        .config_wr  (config_wr),
        .config_addr(config_addr),
        .config_data(config_data),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(negedge clk);
    endtask

    task automatic cfg_write(input logic [1:0] addr, input logic [7:0] data);
        config_wr   = 1'b1;
        config_addr = addr;
        config_data = data;
        cycle();
        config_wr   = 1'b0;
    endtask

    // Called at a negedge where a grant is visible: check it, end the tenure
    // with done, check the two grant-free cycles, and set req before the
    // next IDLE sampling edge.
    task automatic serve(input string tag, input logic [3:0] exp_g, input logic [1:0] exp_id,
                         input logic [3:0] req_after);
        check({tag, "_grant"}, grant, exp_g);
        check({tag, "_id"}, grant_id, exp_id);
        check({tag, "_valid"}, grant_valid, 1'b1);
        done = exp_g;
        cycle();
        done = 4'b0000;
        check({tag, "_rel_grant"}, grant, 4'b0000);
        check({tag, "_rel_valid"}, grant_valid, 1'b0);
        check({tag, "_rel_id_hold"}, grant_id, exp_id);
        check({tag, "_rel_timeout"}, timeout, 1'b0);
        cycle();
        check({tag, "_turn_grant"}, grant, 4'b0000);
        req = req_after;
        cycle();
    endtask

    initial begin
        reset       = 1'b1;
        req         = '0;
        done        = '0;
        config_wr   = 1'b0;
        config_addr = '0;
        config_data = '0;
        repeat (2) cycle();
        check("rst_grant", grant, 4'b0000);
        check("rst_valid", grant_valid, 1'b0);
        check("rst_id", grant_id, 2'd0);
        check("rst_timeout", timeout, 1'b0);
        reset = 1'b0;
        cycle();
        check("idle_grant", grant, 4'b0000);

        // 1: single requester, done release
        req = 4'b0001;
        cycle();
        serve("t1", 4'b0001, 2'd0, 4'b0000);
        check("t1_idle", grant, 4'b0000);

        // 2: all requesting, round-robin from ptr=1
        req = 4'b1111;
        cycle();
        serve("t2a", 4'b0010, 2'd1, 4'b1111);
        serve("t2b", 4'b0100, 2'd2, 4'b1111);
        serve("t2c", 4'b1000, 2'd3, 4'b1111);
        serve("t2d", 4'b0001, 2'd0, 4'b1111);
        serve("t2e", 4'b0010, 2'd1, 4'b0000);

        // 3: mask 0101, ptr=2
        cfg_write(2'b00, 8'h05);
        req = 4'b1111;
        cycle();
        serve("t3a", 4'b0100, 2'd2, 4'b1111);
        serve("t3b", 4'b0001, 2'd0, 4'b1111);
        serve("t3c", 4'b0100, 2'd2, 4'b1111);
        serve("t3d", 4'b0001, 2'd0, 4'b0000);

        // 3b: mask 0 blocks grants; same-edge write uses old mask; no revoke
        cfg_write(2'b00, 8'h00);
        req = 4'b1111;
        cycle();
        check("m0_grant_a", grant, 4'b0000);
        cycle();
        check("m0_grant_b", grant, 4'b0000);
        cfg_write(2'b00, 8'h0F);
        check("m_same_edge_old", grant, 4'b0000);
        cycle();
        check("m_new_grant", grant, 4'b0010);
        cfg_write(2'b00, 8'h00);
        check("m_no_revoke", grant, 4'b0010);
        serve("t3e", 4'b0010, 2'd1, 4'b0000);
        cfg_write(2'b00, 8'h0F);

        // 4: req drop release, foreign done/req ignored, then 1000 served
        req = 4'b0010;
        cycle();
        check("t4_grant", grant, 4'b0010);
        check("t4_id", grant_id, 2'd1);
        done = 4'b1000;
        req  = 4'b0011;
        cycle();
        check("t4_foreign_hold", grant, 4'b0010);
        done = 4'b0000;
        req  = 4'b1000;
        cycle();
        check("t4_drop_grant", grant, 4'b0000);
        check("t4_drop_timeout", timeout, 1'b0);
        cycle();
        check("t4_turn_grant", grant, 4'b0000);
        cycle();
        serve("t4b", 4'b1000, 2'd3, 4'b0000);

        // 5: tenure limit, ptr=0
        cfg_write(2'b01, 8'd4);
`ifdef BUS_GRANT_TIMEOUT_EN
        req = 4'b0110;
        cycle();
        for (int k = 0; k < 4; k++) begin
            check("t5_held", grant, 4'b0010);
            check("t5_no_to", timeout, 1'b0);
            cycle();
        end
        check("t5_expired", grant, 4'b0000);
        check("t5_timeout", timeout, 1'b1);
        cycle();
        check("t5_to_pulse_end", timeout, 1'b0);
        check("t5_turn", grant, 4'b0000);
        cycle();
        for (int k = 0; k < 3; k++) begin
            check("t5_next", grant, 4'b0100);
            cycle();
        end
        check("t5_next4", grant, 4'b0100);
        done = 4'b0100;
        req  = 4'b0000;
        cycle();
        check("t5_done_at_exp", grant, 4'b0000);
        check("t5_done_no_to", timeout, 1'b0);
        done = 4'b0000;
        cycle();
        cfg_write(2'b01, 8'd0);
`else
        req = 4'b0010;
        cycle();
        for (int k = 0; k < 8; k++) begin
            check("t5_unlimited", grant, 4'b0010);
            check("t5_no_to", timeout, 1'b0);
            cycle();
        end
        serve("t5b", 4'b0010, 2'd1, 4'b0000);
`endif

        // 6: async reset mid-grant restores mask and ptr
        cfg_write(2'b00, 8'h02);
        req = 4'b1111;
        cycle();
        check("t6_pre", grant, 4'b0010);
        #2;
        reset = 1'b1;
        #1;
        check("t6_async_grant", grant, 4'b0000);
        check("t6_async_valid", grant_valid, 1'b0);
        check("t6_async_id", grant_id, 2'd0);
        check("t6_async_to", timeout, 1'b0);
        cycle();
        reset = 1'b0;
        cycle();
        serve("t6", 4'b0001, 2'd0, 4'b0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
